// File: rtl/stair_draw_arbiter.sv
// rtl/stair_draw_arbiter.sv - round-robin arbiter sharing one VGA pixel port among stair engines
// Optional: STAIR_ARB_ERASE_PRIORITY_EN gives requester 0 fixed top priority.
module stair_draw_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int GAP_CYCLES = 1,
  parameter int MAX_GRANT  = 4095
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     done,
  input  logic [NUM_REQ-1:0]     plot_in,
  input  logic [8*NUM_REQ-1:0]   x_in,
  input  logic [7*NUM_REQ-1:0]   y_in,
  input  logic [3*NUM_REQ-1:0]   colour_in,
  output logic [NUM_REQ-1:0]     grant,
  output logic [7:0]             x,
  output logic [6:0]             y,
  output logic [2:0]             colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t               state, state_nx;
  logic [NUM_REQ-1:0]   grant_nx;
  logic [1:0]           gidx, gidx_nx;
  logic [1:0]           rr_ptr, rr_nx;
  logic [15:0]          wd_cnt, wd_nx;
  logic [3:0]           gap_cnt, gap_nx;
  logic [7:0]           x_nx;
  logic [6:0]           y_nx;
  logic [2:0]           colour_nx;
  logic                 plot_nx;
  logic                 terr_nx;

  logic [1:0]           win_idx;
  logic                 win_found;
  int                   win_pos;

  logic                 sel_plot;
  logic                 sel_done;
  logic [7:0]           sel_x;
  logic [6:0]           sel_y;
  logic [2:0]           sel_colour;
  logic                 leave;

  // Rotating search from rr_ptr; constant-index inner loop keeps selects static.
  always_comb begin
    win_idx   = 2'd0;
    win_found = 1'b0;
    win_pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      win_pos = int'(rr_ptr) + k;
      if (win_pos >= NUM_REQ) win_pos = win_pos - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found && (i == win_pos) && req[i]) begin
          win_found = 1'b1;
          win_idx   = 2'(i);
        end
      end
    end
`ifdef STAIR_ARB_ERASE_PRIORITY_EN
    if (req[0]) begin
      win_found = 1'b1;
      win_idx   = 2'd0;
    end
`endif
  end

  always_comb begin
    sel_plot   = 1'b0;
    sel_done   = 1'b0;
    sel_x      = 8'd0;
    sel_y      = 7'd0;
    sel_colour = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx == 2'(i)) begin
        sel_plot   = plot_in[i];
        sel_done   = done[i];
        sel_x      = x_in[8*i +: 8];
        sel_y      = y_in[7*i +: 7];
        sel_colour = colour_in[3*i +: 3];
      end
    end
  end

  always_comb begin
    state_nx  = state;
    grant_nx  = grant;
    gidx_nx   = gidx;
    rr_nx     = rr_ptr;
    wd_nx     = wd_cnt;
    gap_nx    = gap_cnt;
    x_nx      = x;
    y_nx      = y;
    colour_nx = colour;
    plot_nx   = 1'b0;
    terr_nx   = timeout_err;
    leave     = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_found) begin
          state_nx = S_GRANT;
          gidx_nx  = win_idx;
          wd_nx    = 16'd0;
          for (int i = 0; i < NUM_REQ; i++) grant_nx[i] = (win_idx == 2'(i));
        end
      end
      S_GRANT: begin
        plot_nx   = sel_plot;
        x_nx      = sel_x;
        y_nx      = sel_y;
        colour_nx = sel_colour;
        wd_nx     = wd_cnt + 16'd1;
        // A done in the expiry cycle counts as a normal finish, not a timeout.
        if (sel_done) begin
          leave = 1'b1;
        end else if (wd_nx == 16'(MAX_GRANT)) begin
          leave   = 1'b1;
          terr_nx = 1'b1;
        end
        if (leave) begin
          grant_nx = '0;
          gap_nx   = 4'd0;
          if (GAP_CYCLES == 0) state_nx = S_IDLE;
          else                 state_nx = S_GAP;
`ifdef STAIR_ARB_ERASE_PRIORITY_EN
          if (gidx != 2'd0) begin
            if (gidx == 2'(NUM_REQ-1)) rr_nx = 2'd0;
            else                       rr_nx = gidx + 2'd1;
          end
`else
          if (gidx == 2'(NUM_REQ-1)) rr_nx = 2'd0;
          else                       rr_nx = gidx + 2'd1;
`endif
        end
      end
      S_GAP: begin
        if (gap_cnt == 4'(GAP_CYCLES-1)) state_nx = S_IDLE;
        else                             gap_nx   = gap_cnt + 4'd1;
      end
      default: begin
        state_nx = S_IDLE;
        grant_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      grant       <= '0;
      gidx        <= 2'd0;
      rr_ptr      <= 2'd0;
      wd_cnt      <= 16'd0;
      gap_cnt     <= 4'd0;
      x           <= 8'd0;
      y           <= 7'd0;
      colour      <= 3'd0;
      plot        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      grant       <= grant_nx;
      gidx        <= gidx_nx;
      rr_ptr      <= rr_nx;
      wd_cnt      <= wd_nx;
      gap_cnt     <= gap_nx;
      x           <= x_nx;
      y           <= y_nx;
      colour      <= colour_nx;
      plot        <= plot_nx;
      timeout_err <= terr_nx;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_stair_draw_arbiter.sv
// tb/tb_stair_draw_arbiter.sv - directed vector bench for stair_draw_arbiter
module tb_stair_draw_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req = '0, done = '0, plot_in = '0;
  logic [15:0] x_in = '0;
  logic [13:0] y_in = '0;
  logic [5:0]  colour_in = '0;

  logic [1:0]  grant, grant_w;
  logic [7:0]  x, x_w;
  logic [6:0]  y, y_w;
  logic [2:0]  colour, colour_w;
  logic        plot, plot_w, busy, busy_w, terr, terr_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  stair_draw_arbiter #(.NUM_REQ(2), .GAP_CYCLES(1), .MAX_GRANT(4095)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .done(done), .plot_in(plot_in),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .grant(grant), .x(x), .y(y),
    .colour(colour), .plot(plot), .busy(busy), .timeout_err(terr));

  stair_draw_arbiter #(.NUM_REQ(2), .GAP_CYCLES(1), .MAX_GRANT(16)) dut_w (
    .clock(clock), .reset_n(reset_n), .req(req), .done(done), .plot_in(plot_in),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .grant(grant_w), .x(x_w), .y(y_w),
    .colour(colour_w), .plot(plot_w), .busy(busy_w), .timeout_err(terr_w));

  typedef struct packed {
    logic [1:0]  req, done, pin;
    logic [15:0] xi;
    logic [13:0] yi;
    logic [5:0]  ci;
    logic [1:0]  eg;
    logic        ep;
    logic [7:0]  ex;
    logic [6:0]  ey;
    logic [2:0]  ec;
    logic        eb;
  } vec_t;

`ifdef STAIR_ARB_ERASE_PRIORITY_EN
  localparam logic [1:0] SECOND_GRANT = 2'b01;
`else
  localparam logic [1:0] SECOND_GRANT = 2'b10;
`endif

  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0; done = '0; plot_in = '0; x_in = '0; y_in = '0; colour_in = '0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int n;
    tbl[0] = '{2'b11, 2'b00, 2'b00, 16'h0000, 14'd0,    6'b000000, 2'b01, 1'b0, 8'd0,  7'd0,  3'd0, 1'b1};
    tbl[1] = '{2'b11, 2'b00, 2'b01, 16'hC80A, 14'd6405, 6'b111001, 2'b01, 1'b1, 8'd10, 7'd5,  3'd1, 1'b1};
    tbl[2] = '{2'b11, 2'b10, 2'b11, 16'hC90B, 14'd6534, 6'b110010, 2'b01, 1'b1, 8'd11, 7'd6,  3'd2, 1'b1};
    tbl[3] = '{2'b11, 2'b00, 2'b10, 16'hCA0B, 14'd6662, 6'b111010, 2'b01, 1'b0, 8'd11, 7'd6,  3'd2, 1'b1};
    tbl[4] = '{2'b11, 2'b01, 2'b01, 16'hCB0D, 14'd6791, 6'b111011, 2'b00, 1'b1, 8'd13, 7'd7,  3'd3, 1'b1};
    tbl[5] = '{2'b11, 2'b00, 2'b11, 16'h6362, 14'd1161, 6'b101101, 2'b00, 1'b0, 8'd13, 7'd7,  3'd3, 1'b0};
    tbl[6] = '{2'b11, 2'b00, 2'b00, 16'h0000, 14'd0,    6'b000000, SECOND_GRANT, 1'b0, 8'd13, 7'd7, 3'd3, 1'b1};
    tbl[7] = '{2'b11, 2'b11, 2'b11, 16'h3232, 14'd2580, 6'b101101, 2'b00, 1'b1, 8'd50, 7'd20, 3'd5, 1'b1};
    tbl[8] = '{2'b11, 2'b00, 2'b00, 16'h0000, 14'd0,    6'b000000, 2'b00, 1'b0, 8'd50, 7'd20, 3'd5, 1'b0};
    tbl[9] = '{2'b11, 2'b00, 2'b00, 16'h0000, 14'd0,    6'b000000, 2'b01, 1'b0, 8'd50, 7'd20, 3'd5, 1'b1};

    do_reset();
    chk("reset_grant", grant, 0);
    chk("reset_plot", plot, 0);
    chk("reset_x", x, 0);
    chk("reset_y", y, 0);
    chk("reset_colour", colour, 0);
    chk("reset_busy", busy, 0);
    chk("reset_timeout", terr, 0);

    // Contention, stray inputs and last-pixel forwarding.
    for (int v = 0; v < 10; v++) begin
      req = tbl[v].req; done = tbl[v].done; plot_in = tbl[v].pin;
      x_in = tbl[v].xi; y_in = tbl[v].yi; colour_in = tbl[v].ci;
      step();
      chk($sformatf("vec%0d_grant", v), grant, tbl[v].eg);
      chk($sformatf("vec%0d_plot", v), plot, tbl[v].ep);
      chk($sformatf("vec%0d_x", v), x, tbl[v].ex);
      chk($sformatf("vec%0d_y", v), y, tbl[v].ey);
      chk($sformatf("vec%0d_colour", v), colour, tbl[v].ec);
      chk($sformatf("vec%0d_busy", v), busy, tbl[v].eb);
    end

    // Single requester streaming 200 pixels.
    do_reset();
    req = 2'b01;
    step();
    chk("single_grant_rise", grant, 1);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      plot_in = 2'b01;
      x_in = {8'd0, 8'(60 + i % 40)};
      y_in = {7'd0, 7'(40 + i / 40)};
      colour_in = 6'b000100;
      done = (i == 199) ? 2'b01 : 2'b00;
      step();
      if (plot === 1'b1 && x == 8'(60 + i % 40) && y == 7'(40 + i / 40) && colour == 3'b100) n++;
      if (i < 199 && grant != 2'b01) chk("single_grant_hold", grant, 1);
    end
    chk("single_pixel_count", n, 200);
    chk("single_grant_drop", grant, 0);
    chk("single_busy_gap", busy, 1);
    req = 2'b00; done = 2'b00; plot_in = 2'b00;
    step();
    chk("single_gap_plot", plot, 0);
    chk("single_idle_busy", busy, 0);
    chk("single_no_timeout", terr, 0);

    // Watchdog on the MAX_GRANT=16 instance.
    do_reset();
    req = 2'b10;
    step();
    chk("wd_grant", grant_w, 2);
    n = 1;
    for (int c = 0; c < 64; c++) begin
      step();
      if (grant_w == 2'b00) break;
      n++;
    end
    chk("wd_grant_cycles", n, 16);
    chk("wd_timeout_set", terr_w, 1);
    req = 2'b11;
    step();
    chk("wd_gap_grant", grant_w, 0);
    step();
    chk("wd_next_from_0", grant_w, 1);
    repeat (3) step();
    chk("wd_timeout_sticky", terr_w, 1);

    // Asynchronous reset mid-grant.
    do_reset();
    req = 2'b01;
    step();
    done = 2'b01; plot_in = 2'b01;
    step();
    chk("ar_first_done", grant, 0);
    req = 2'b00; done = 2'b00; plot_in = 2'b00;
    step();
    req = 2'b10;
    step();
    chk("ar_grant1", grant, 2);
    plot_in = 2'b10; x_in = 16'h7700;
    step();
    chk("ar_plot_before", plot, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("ar_grant_cleared", grant, 0);
    chk("ar_plot_cleared", plot, 0);
    chk("ar_busy_cleared", busy, 0);
    chk("ar_x_cleared", x, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    req = 2'b11; plot_in = 2'b00; x_in = '0;
    step();
    chk("ar_restart_rr0", grant, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
